// File: rtl/uart_fir_sequencer.sv
// uart_fir_sequencer
//   Frame sequencer between the UART receiver/transmitter pair and the FIR
//   core. Received bytes are paired little-endian into 16-bit samples and
//   offered to the FIR with valid/ready. Each FIR result is captured and sent
//   back out as two bytes, low byte first, through the transmitter's
//   start/busy handshake.
//
// Optional feature (compile-time macro SEQ_RX_TIMEOUT_EN):
//   When defined, a half-received sample is abandoned if the second byte does
//   not arrive within TIMEOUT_CYCLES clocks. When undefined, the receive FSM
//   waits for the second byte indefinitely.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous reset, active low
//   RxD_data_ready one-cycle strobe, RxD_data valid
//   RxD_data       received byte
//   fir_in_valid   sample offered to the FIR
//   fir_in_data    sample {high byte, low byte}
//   fir_in_ready   FIR accepts the sample when valid & ready
//   fir_out_valid  one-cycle strobe, fir_out_data valid
//   fir_out_data   FIR result
//   TxD_start      one-cycle start pulse to the transmitter
//   TxD_data       byte to transmit, held until busy falls
//   TxD_busy       transmitter busy
//   ovr_clr        clears overrun
//   overrun        sticky flag: a sample or a result was dropped
module uart_fir_sequencer #(
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RxD_data_ready,
  input  logic [7:0]  RxD_data,
  output logic        fir_in_valid,
  output logic [15:0] fir_in_data,
  input  logic        fir_in_ready,
  input  logic        fir_out_valid,
  input  logic [15:0] fir_out_data,
  output logic        TxD_start,
  output logic [7:0]  TxD_data,
  input  logic        TxD_busy,
  input  logic        ovr_clr,
  output logic        overrun
);

  typedef enum logic {RX_LO, RX_HI} rx_state_t;
  typedef enum logic [2:0] {
    TX_IDLE, TX_START_LO, TX_WAIT_HI_LO, TX_WAIT_LO_LO,
    TX_START_HI, TX_WAIT_HI_HI, TX_WAIT_LO_HI
  } tx_state_t;

  rx_state_t   rx_state, rx_state_next;
  tx_state_t   tx_state, tx_state_next;
  logic [7:0]  low_byte;
  logic [15:0] res_data;
  logic        res_full;
  logic        sample_done, rx_timeout;
  logic        drop_sample, drop_result;
  logic        res_clear, res_accept;
  logic        tx_load_lo, tx_load_hi;

  // Elaboration-time sanity check on the timeout length.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

`ifdef SEQ_RX_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] rx_timer;

  // Counts clocks spent in RX_HI since the low byte; any strobe restarts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      rx_timer <= '0;
    else if (rx_state != RX_HI || RxD_data_ready)
      rx_timer <= '0;
    else
      rx_timer <= rx_timer + 1'b1;
  end

  assign rx_timeout = (rx_state == RX_HI) && !RxD_data_ready &&
                      (rx_timer == TMR_W'(TIMEOUT_CYCLES - 1));
`else
  assign rx_timeout = 1'b0;
`endif

  // Receive FSM state register and low-byte holding register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state <= RX_LO;
      low_byte <= 8'h00;
    end else begin
      rx_state <= rx_state_next;
      if (rx_state == RX_LO && RxD_data_ready)
        low_byte <= RxD_data;
    end
  end

  // Receive FSM next state; sample_done marks the second byte of a pair.
  always_comb begin
    rx_state_next = rx_state;
    sample_done   = 1'b0;
    case (rx_state)
      RX_LO: if (RxD_data_ready) rx_state_next = RX_HI;
      RX_HI: begin
        if (RxD_data_ready) begin
          sample_done   = 1'b1;
          rx_state_next = RX_LO;
        end else if (rx_timeout) begin
          rx_state_next = RX_LO;
        end
      end
      default: rx_state_next = RX_LO;
    endcase
  end

  // A held sample that is being accepted this cycle frees the slot, so a
  // simultaneous new sample is loaded rather than dropped.
  assign drop_sample = sample_done && fir_in_valid && !fir_in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fir_in_valid <= 1'b0;
      fir_in_data  <= 16'h0000;
    end else if (sample_done && (!fir_in_valid || fir_in_ready)) begin
      fir_in_valid <= 1'b1;
      fir_in_data  <= {RxD_data, low_byte};
    end else if (fir_in_valid && fir_in_ready) begin
      fir_in_valid <= 1'b0;
    end
  end

  // The result slot frees on the cycle the high byte finishes, and a result
  // arriving in that same cycle is taken into the freed slot.
  assign res_clear   = (tx_state == TX_WAIT_LO_HI) && !TxD_busy;
  assign res_accept  = fir_out_valid && (!res_full || res_clear);
  assign drop_result = fir_out_valid && res_full && !res_clear;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_full <= 1'b0;
      res_data <= 16'h0000;
    end else if (res_accept) begin
      res_full <= 1'b1;
      res_data <= fir_out_data;
    end else if (res_clear) begin
      res_full <= 1'b0;
    end
  end

  // Transmit FSM state register; TxD_data is loaded on entry to each start
  // state so it stays stable for the whole byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= TX_IDLE;
      TxD_data <= 8'h00;
    end else begin
      tx_state <= tx_state_next;
      if (tx_load_lo)
        TxD_data <= res_data[7:0];
      else if (tx_load_hi)
        TxD_data <= res_data[15:8];
    end
  end

  // Transmit FSM next state and start pulse.
  always_comb begin
    tx_state_next = tx_state;
    TxD_start     = 1'b0;
    tx_load_lo    = 1'b0;
    tx_load_hi    = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (res_full && !TxD_busy) begin
          tx_state_next = TX_START_LO;
          tx_load_lo    = 1'b1;
        end
      end
      TX_START_LO: begin
        TxD_start     = 1'b1;
        tx_state_next = TX_WAIT_HI_LO;
      end
      TX_WAIT_HI_LO: if (TxD_busy) tx_state_next = TX_WAIT_LO_LO;
      TX_WAIT_LO_LO: begin
        if (!TxD_busy) begin
          tx_state_next = TX_START_HI;
          tx_load_hi    = 1'b1;
        end
      end
      TX_START_HI: begin
        TxD_start     = 1'b1;
        tx_state_next = TX_WAIT_HI_HI;
      end
      TX_WAIT_HI_HI: if (TxD_busy) tx_state_next = TX_WAIT_LO_HI;
      TX_WAIT_LO_HI: if (!TxD_busy) tx_state_next = TX_IDLE;
      default: tx_state_next = TX_IDLE;
    endcase
  end

  // Sticky drop flag; a new drop outranks a clear in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      overrun <= 1'b0;
    else if (drop_sample || drop_result)
      overrun <= 1'b1;
    else if (ovr_clr)
      overrun <= 1'b0;
  end

endmodule
